// File: rtl/mode_shift_reg.sv
// mode_shift_reg: multi-mode shift register with parallel load, serial-in
// word assembly (S2P) and flow-controlled serial-out emission (P2S).
//
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   mode[1:0]   00 hold, 01 parallel load, 10 serial-in, 11 serial-out
//   din         parallel load data
//   sin         serial input bit, qualified by sin_valid
//   sout_ready  downstream accepts sout this cycle
//   q           register contents
//   sout        serial output bit (output end of q)
//   sout_valid  sout carries a bit waiting to be accepted
//   word_valid  one-cycle pulse: q holds a freshly completed S2P word
//   done        one-cycle pulse: last P2S bit was accepted
//   busy        S2P word partially assembled, or P2S bits still pending
module mode_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sout_ready,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_S2P  = 2'b10;
  localparam logic [1:0] MODE_P2S  = 2'b11;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [CW-1:0]    in_cnt, in_cnt_nxt_s;
  logic [CW-1:0]    rem, rem_nxt_s;
  logic             word_valid_r, word_valid_nxt_s;
  logic             done_r, done_nxt_s;
  logic             in_s2p_r;          // mode was 10 on the previous edge
  logic [WIDTH-1:0] shift_in_s;
  logic [WIDTH-1:0] shift_out_s;
  logic             sout_valid_s;
  logic             xfer_s;
  logic [CW-1:0]    in_cnt_idle_s;

  // Shifted candidates for both directions; the output end is the bit sout shows.
  assign shift_in_s  = MSB_FIRST ? {q_r[WIDTH-2:0], sin}  : {sin, q_r[WIDTH-1:1]};
  assign shift_out_s = MSB_FIRST ? {q_r[WIDTH-2:0], 1'b0} : {1'b0, q_r[WIDTH-1:1]};

  assign sout_valid_s = (mode == MODE_P2S) && (rem != CNT_ZERO);
  assign xfer_s       = sout_valid_s && sout_ready;

  // Dropping out of S2P abandons a partial word (bits stay in q); otherwise hold.
  assign in_cnt_idle_s = in_s2p_r ? CNT_ZERO : in_cnt;

  // Next-state selection for the data register, counters and event pulses.
  always_comb begin
    q_nxt_s          = q_r;
    in_cnt_nxt_s     = in_cnt;
    rem_nxt_s        = rem;
    word_valid_nxt_s = 1'b0;
    done_nxt_s       = 1'b0;
    case (mode)
      MODE_HOLD: begin
        in_cnt_nxt_s = in_cnt_idle_s;
      end
      MODE_LOAD: begin
        q_nxt_s      = din;
        in_cnt_nxt_s = CNT_ZERO;
        rem_nxt_s    = CNT_FULL;
      end
      MODE_S2P: begin
        // Entering S2P throws away any paused P2S emission.
        if (!in_s2p_r) begin
          rem_nxt_s = CNT_ZERO;
        end else begin
          rem_nxt_s = rem;
        end
        if (sin_valid) begin
          q_nxt_s = shift_in_s;
          if (in_cnt == CNT_LAST) begin
            // Word complete: arm it for emission and flag it next cycle.
            in_cnt_nxt_s     = CNT_ZERO;
            rem_nxt_s        = CNT_FULL;
            word_valid_nxt_s = 1'b1;
          end else begin
            in_cnt_nxt_s = in_cnt + CNT_ONE;
          end
        end else begin
          q_nxt_s      = q_r;
          in_cnt_nxt_s = in_cnt;
        end
      end
      MODE_P2S: begin
        in_cnt_nxt_s = in_cnt_idle_s;
        if (xfer_s) begin
          q_nxt_s    = shift_out_s;
          rem_nxt_s  = rem - CNT_ONE;
          done_nxt_s = (rem == CNT_ONE);
        end else begin
          q_nxt_s   = q_r;
          rem_nxt_s = rem;
        end
      end
      default: begin
        q_nxt_s      = q_r;
        in_cnt_nxt_s = in_cnt;
        rem_nxt_s    = rem;
      end
    endcase
  end

  // State registers with synchronous active-low reset overriding every mode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r          <= {WIDTH{1'b0}};
      in_cnt       <= CNT_ZERO;
      rem          <= CNT_ZERO;
      word_valid_r <= 1'b0;
      done_r       <= 1'b0;
      in_s2p_r     <= 1'b0;
    end else begin
      q_r          <= q_nxt_s;
      in_cnt       <= in_cnt_nxt_s;
      rem          <= rem_nxt_s;
      word_valid_r <= word_valid_nxt_s;
      done_r       <= done_nxt_s;
      in_s2p_r     <= (mode == MODE_S2P);
    end
  end

  assign q          = q_r;
  assign sout       = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];
  assign sout_valid = sout_valid_s;
  assign word_valid = word_valid_r;
  assign done       = done_r;
  assign busy       = (in_cnt != CNT_ZERO) || (rem != CNT_ZERO);

endmodule
